// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizes for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int ADDR_W       = 8;
  localparam int DATA_W       = 8;
  localparam int STARVE_LIMIT = 4;
  localparam int STARVE_W     = 4;

  typedef enum logic {
    IDLE,
    DBG_LOCKED
  } arb_state_e;

  typedef enum logic [1:0] {
    NONE,
    CORE,
    DBG
  } owner_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// Saturating up-counter with synchronous clear; flags when the limit is reached.
module dmem_arb_starve_ctr #(
  parameter int CNT_W = 4,
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_limit_o
);

  localparam logic [CNT_W-1:0] LIM = CNT_W'(LIMIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear wins over increment; hold once the limit is reached.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i && (cnt_q != LIM))
      cnt_d = cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign at_limit_o = (cnt_q == LIM);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data RAM.
// Core has fixed priority; the debug port is forced through after it has lost
// STARVE_LIMIT consecutive conflicts, and can hold the RAM with dbg_lock.
// Optional build macro DMEM_ARB_STATS_EN adds conflict_cnt / forced_cnt.
module dmem_arbiter #(
  parameter int ADDR_W       = dmem_arb_pkg::ADDR_W,
  parameter int DATA_W       = dmem_arb_pkg::DATA_W,
  parameter int STARVE_LIMIT = dmem_arb_pkg::STARVE_LIMIT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  input  logic              dbg_lock,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]       conflict_cnt,
  output logic [15:0]       forced_cnt
`endif
);

  import dmem_arb_pkg::*;

  arb_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [DATA_W-1:0] core_rdata_q, dbg_rdata_q;
  logic              starved;

  dmem_arb_starve_ctr #(
    .CNT_W (STARVE_W),
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk        (clk),
    .rst_n      (rst_n),
    .inc_i      (dbg_req && !dbg_gnt),
    .clr_i      (!dbg_req || dbg_gnt),
    .at_limit_o (starved)
  );

  // Grant decision and next state; nothing is granted while reset is held.
  always_comb begin
    core_gnt = 1'b0;
    dbg_gnt  = 1'b0;
    state_d  = state_q;
    if (rst_n) begin
      case (state_q)
        IDLE: begin
          if (core_req && dbg_req) begin
            if (starved) dbg_gnt  = 1'b1;
            else         core_gnt = 1'b1;
          end else if (core_req) begin
            core_gnt = 1'b1;
          end else if (dbg_req) begin
            dbg_gnt = 1'b1;
          end
          if (dbg_gnt && dbg_lock)
            state_d = DBG_LOCKED;
        end
        DBG_LOCKED: begin
          dbg_gnt = dbg_req;
          if (!dbg_lock)
            state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // RAM port follows whichever requester holds the grant this cycle.
  always_comb begin
    ram_en    = core_gnt | dbg_gnt;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    owner_d   = NONE;
    if (core_gnt) begin
      ram_we    = core_we;
      ram_addr  = core_addr;
      ram_wdata = core_wdata;
      if (!core_we) owner_d = CORE;
    end else if (dbg_gnt) begin
      ram_we    = dbg_we;
      ram_addr  = dbg_addr;
      ram_wdata = dbg_wdata;
      if (!dbg_we) owner_d = DBG;
    end
  end

  // Read return: owner of last cycle's read sees RAM data, the other port holds.
  always_comb begin
    core_rvalid = (owner_q == CORE);
    dbg_rvalid  = (owner_q == DBG);
    core_rdata  = core_rvalid ? ram_rdata : core_rdata_q;
    dbg_rdata   = dbg_rvalid  ? ram_rdata : dbg_rdata_q;
  end

  // FSM state, pending read owner and held read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= NONE;
      core_rdata_q <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      core_rdata_q <= core_rdata;
      dbg_rdata_q  <= dbg_rdata;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] conflict_q, forced_q;
  logic        forced_grant;

  assign forced_grant = (state_q == IDLE) && core_req && dbg_req && starved && rst_n;

  // Free-running wrap-around statistics counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_q <= '0;
      forced_q   <= '0;
    end else begin
      if (core_req && dbg_req) conflict_q <= conflict_q + 16'd1;
      if (forced_grant)        forced_q   <= forced_q + 16'd1;
    end
  end

  assign conflict_cnt = conflict_q;
  assign forced_cnt   = forced_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a read-return scoreboard and a RAM model.
module tb_dmem_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       core_req, core_we;
  logic [7:0] core_addr, core_wdata;
  logic       core_gnt, core_rvalid;
  logic [7:0] core_rdata;
  logic       dbg_req, dbg_we, dbg_lock;
  logic [7:0] dbg_addr, dbg_wdata;
  logic       dbg_gnt, dbg_rvalid;
  logic [7:0] dbg_rdata;
  logic       ram_en, ram_we;
  logic [7:0] ram_addr, ram_wdata, ram_rdata;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0] conflict_cnt, forced_cnt;
`endif

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(8), .DATA_W(8), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
`ifdef DMEM_ARB_STATS_EN
    , .conflict_cnt(conflict_cnt), .forced_cnt(forced_cnt)
`endif
  );

  // Single-port RAM model, registered read.
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  typedef struct {
    int         due;
    logic [7:0] data;
  } exp_t;

  exp_t q_core[$];
  exp_t q_dbg[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_rd();
    logic ev;
    ev = (q_core.size() > 0) && (q_core[0].due == cyc);
    chk("core_rvalid", {31'd0, core_rvalid}, {31'd0, ev});
    if (ev) begin
      chk("core_rdata", {24'd0, core_rdata}, {24'd0, q_core[0].data});
      void'(q_core.pop_front());
    end
    ev = (q_dbg.size() > 0) && (q_dbg[0].due == cyc);
    chk("dbg_rvalid", {31'd0, dbg_rvalid}, {31'd0, ev});
    if (ev) begin
      chk("dbg_rdata", {24'd0, dbg_rdata}, {24'd0, q_dbg[0].data});
      void'(q_dbg.pop_front());
    end
  endtask

  task automatic next();
    @(negedge clk);
    cyc++;
    check_rd();
  endtask

  task automatic set_core(input logic req, input logic we, input logic [7:0] a, input logic [7:0] d);
    core_req = req; core_we = we; core_addr = a; core_wdata = d;
  endtask

  task automatic set_dbg(input logic req, input logic we, input logic [7:0] a, input logic [7:0] d,
                         input logic lock);
    dbg_req = req; dbg_we = we; dbg_addr = a; dbg_wdata = d; dbg_lock = lock;
  endtask

  task automatic push_core(input logic [7:0] d);
    q_core.push_back('{cyc + 1, d});
  endtask

  task automatic push_dbg(input logic [7:0] d);
    q_dbg.push_back('{cyc + 1, d});
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic exp_d;
    rst_n = 1'b0;
    set_core(1'b1, 1'b0, 8'h10, 8'h00);
    set_dbg(1'b1, 1'b0, 8'h01, 8'h00, 1'b0);
    #1;
    // Reset: everything quiet even with requests pending.
    chk("rst_core_gnt", {31'd0, core_gnt}, 32'd0);
    chk("rst_dbg_gnt", {31'd0, dbg_gnt}, 32'd0);
    chk("rst_ram_en", {31'd0, ram_en}, 32'd0);
    chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
    chk("rst_ram_addr", {24'd0, ram_addr}, 32'd0);
    chk("rst_core_rdata", {24'd0, core_rdata}, 32'd0);
    chk("rst_dbg_rdata", {24'd0, dbg_rdata}, 32'd0);
    next();
    set_core(1'b0, 1'b0, 8'h00, 8'h00);
    set_dbg(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    rst_n = 1'b1;

    // Preload RAM through both ports.
    next(); set_core(1'b1, 1'b1, 8'h10, 8'hA5); #1;
    chk("pre_core_gnt", {31'd0, core_gnt}, 32'd1);
    chk("pre_ram_we", {31'd0, ram_we}, 32'd1);
    next(); set_core(1'b1, 1'b1, 8'h00, 8'h3C);
    next(); set_core(1'b0, 1'b0, 8'h00, 8'h00); set_dbg(1'b1, 1'b1, 8'h01, 8'hC3, 1'b0); #1;
    chk("pre_dbg_gnt", {31'd0, dbg_gnt}, 32'd1);
    chk("pre_dbg_wdata", {24'd0, ram_wdata}, 32'h0000_00C3);
    next(); set_dbg(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

    // Conflict: core wins four times, dbg forced on the fifth, repeating.
    for (int k = 0; k < 10; k++) begin
      next();
      set_core(1'b1, 1'b0, 8'h10, 8'h00);
      set_dbg(1'b1, 1'b0, 8'h01, 8'h00, 1'b0);
      #1;
      exp_d = (k % 5 == 4);
      chk("cf_core_gnt", {31'd0, core_gnt}, {31'd0, !exp_d});
      chk("cf_dbg_gnt", {31'd0, dbg_gnt}, {31'd0, exp_d});
      chk("cf_ram_addr", {24'd0, ram_addr}, exp_d ? 32'h01 : 32'h10);
      if (exp_d) push_dbg(8'hC3);
      else       push_core(8'hA5);
    end
    next();
    set_core(1'b0, 1'b0, 8'h00, 8'h00);
    set_dbg(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    #1;
`ifdef DMEM_ARB_STATS_EN
    chk("conflict_cnt", {16'd0, conflict_cnt}, 32'd10);
    chk("forced_cnt", {16'd0, forced_cnt}, 32'd2);
`endif

    // Core-only read of 0x10; dbg read data must be held meanwhile.
    next(); set_core(1'b1, 1'b0, 8'h10, 8'h00); #1;
    chk("cr_core_gnt", {31'd0, core_gnt}, 32'd1);
    chk("cr_dbg_gnt", {31'd0, dbg_gnt}, 32'd0);
    chk("cr_ram_en", {31'd0, ram_en}, 32'd1);
    push_core(8'hA5);
    next(); set_core(1'b0, 1'b0, 8'h00, 8'h00); #1;
    chk("cr_dbg_hold", {24'd0, dbg_rdata}, 32'h0000_00C3);

    // Alternating reads: core 0x00 then dbg 0x01.
    next(); set_core(1'b1, 1'b0, 8'h00, 8'h00); push_core(8'h3C);
    next(); set_core(1'b0, 1'b0, 8'h00, 8'h00); set_dbg(1'b1, 1'b0, 8'h01, 8'h00, 1'b0); #1;
    chk("alt_dbg_gnt", {31'd0, dbg_gnt}, 32'd1);
    push_dbg(8'hC3);
    next(); set_dbg(1'b0, 1'b0, 8'h00, 8'h00, 1'b0); #1;
    chk("alt_core_hold", {24'd0, core_rdata}, 32'h0000_003C);

    // Locked burst: dbg writes 0x20..0x23 while core keeps requesting.
    next(); set_dbg(1'b1, 1'b1, 8'h20, 8'h01, 1'b1); #1;
    chk("lk_dbg_gnt0", {31'd0, dbg_gnt}, 32'd1);
    next(); set_core(1'b1, 1'b0, 8'h40, 8'h00); set_dbg(1'b0, 1'b1, 8'h00, 8'h00, 1'b1); #1;
    chk("lk_gap_core_gnt", {31'd0, core_gnt}, 32'd0);
    chk("lk_gap_ram_en", {31'd0, ram_en}, 32'd0);
    for (int i = 1; i < 4; i++) begin
      next();
      set_dbg(1'b1, 1'b1, 8'h20 + 8'(i), 8'(i + 1), 1'b1);
      #1;
      chk("lk_core_gnt", {31'd0, core_gnt}, 32'd0);
      chk("lk_dbg_gnt", {31'd0, dbg_gnt}, 32'd1);
      chk("lk_ram_addr", {24'd0, ram_addr}, 32'h20 + i);
      chk("lk_ram_wdata", {24'd0, ram_wdata}, 32'(i + 1));
    end
    next(); set_dbg(1'b0, 1'b0, 8'h00, 8'h00, 1'b0); #1;
    chk("lk_drop_core_gnt", {31'd0, core_gnt}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      next();
      set_core(1'b1, 1'b0, 8'h20 + 8'(i), 8'h00);
      #1;
      chk("rb_core_gnt", {31'd0, core_gnt}, 32'd1);
      push_core(8'(i + 1));
    end
    next(); set_core(1'b0, 1'b0, 8'h00, 8'h00);

    // dbg_lock without a grant must not lock out the core.
    next(); set_core(1'b1, 1'b1, 8'h50, 8'h77); set_dbg(1'b1, 1'b1, 8'h60, 8'h11, 1'b1); #1;
    chk("nl_core_gnt0", {31'd0, core_gnt}, 32'd1);
    chk("nl_dbg_gnt0", {31'd0, dbg_gnt}, 32'd0);
    next(); set_core(1'b1, 1'b1, 8'h51, 8'h78); set_dbg(1'b0, 1'b0, 8'h00, 8'h00, 1'b0); #1;
    chk("nl_core_gnt1", {31'd0, core_gnt}, 32'd1);
    next(); set_core(1'b0, 1'b0, 8'h00, 8'h00);

    // Reset between a read grant and its return.
    next(); set_core(1'b1, 1'b0, 8'h10, 8'h00); #1;
    chk("mr_core_gnt", {31'd0, core_gnt}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mr_core_rvalid", {31'd0, core_rvalid}, 32'd0);
    chk("mr_dbg_rvalid", {31'd0, dbg_rvalid}, 32'd0);
    chk("mr_core_rdata", {24'd0, core_rdata}, 32'd0);
    chk("mr_dbg_rdata", {24'd0, dbg_rdata}, 32'd0);
    chk("mr_core_gnt_rst", {31'd0, core_gnt}, 32'd0);
    chk("mr_ram_en", {31'd0, ram_en}, 32'd0);
    chk("mr_ram_addr", {24'd0, ram_addr}, 32'd0);
`ifdef DMEM_ARB_STATS_EN
    chk("mr_conflict_cnt", {16'd0, conflict_cnt}, 32'd0);
`endif
    next();
    set_core(1'b0, 1'b0, 8'h00, 8'h00);
    rst_n = 1'b1;
    next(); set_core(1'b1, 1'b0, 8'h10, 8'h00); #1;
    chk("mr_post_gnt", {31'd0, core_gnt}, 32'd1);
    push_core(8'hA5);
    next(); set_core(1'b0, 1'b0, 8'h00, 8'h00);
    next();
    chk("sb_core_empty", q_core.size(), 32'd0);
    chk("sb_dbg_empty", q_dbg.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data RAM between two requesters: the core (primary) and a debug/loader port (secondary).
- Sits between the core's dmem control output and the Ram instance in the top level.
- Core has fixed priority; an anti-starvation counter guarantees the debug port a slot.
- Debug may lock the RAM for atomic bursts.

Parameters:
- ADDR_W, 8: RAM address width.
- DATA_W, 8: RAM data width.
- STARVE_LIMIT, 4: number of consecutive cycles dbg may lose a conflict before it is forced a grant. Range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- core_req  in  1  core access request.
- core_we  in  1  core write enable (0 = read).
- core_addr  in  ADDR_W  core address.
- core_wdata  in  DATA_W  core write data.
- core_gnt  out  1  core access accepted this cycle.
- core_rvalid  out  1  core read data valid.
- core_rdata  out  DATA_W  core read data.
- dbg_req, dbg_we, dbg_addr, dbg_wdata  in  1/1/ADDR_W/DATA_W  same meaning for the debug port.
- dbg_lock  in  1  hold RAM ownership while asserted, once dbg holds a grant.
- dbg_gnt, dbg_rvalid, dbg_rdata  out  1/1/DATA_W  same meaning for the debug port.
- ram_en, ram_we  out  1/1  RAM access strobe and write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data, valid one cycle after ram_en with ram_we=0.

Behaviour:
- Clock and reset: clk, plus asynchronous active-low reset rst_n.
- Reset values:
  - state=IDLE, starve_cnt=0, rd_owner=NONE.
  - All gnt, rvalid, ram_en and ram_we are 0; rdata/addr/wdata outputs are 0.
- Grants: combinational from requests and registered state. At most one gnt per cycle.
- RAM drive: ram_* are driven from the granted requester in the same cycle. With no grant, ram_en=0 and ram_we=0.
- FSM states:
  - IDLE:
    - If only one requester: grant it.
    - If both request: grant core, unless starve_cnt==STARVE_LIMIT, in which case grant dbg.
    - A dbg grant with dbg_lock=1 moves to DBG_LOCKED.
  - DBG_LOCKED:
    - core_gnt=0.
    - dbg_gnt=dbg_req.
    - Stay while dbg_lock=1; when dbg_lock=0, return to IDLE at the next edge.
    - A dbg_req=0 cycle inside the lock leaves the RAM idle but keeps the lock.
- starve_cnt:
  - Increments when dbg_req=1 and dbg_gnt=0.
  - Clears on any dbg_gnt or when dbg_req=0.
  - Saturates at STARVE_LIMIT.
- Read return: a granted read registers its owner. Next cycle, the owner's rvalid=1 and its rdata=ram_rdata; the other port's rdata holds its last value.
- Pipelining: back-to-back reads to alternating owners are legal; rvalid follows each owner with 1-cycle latency.
- Writes: complete in the grant cycle; no rvalid.
- Simultaneous core and dbg requests on the same address: no special case; the order is the grant order.
- dbg_lock asserted without dbg_gnt has no effect.
- Reset mid-read: the pending rvalid is discarded.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- With it defined, the block adds outputs:
  - conflict_cnt (16-bit): counts cycles with both requests active; wraps at 0xFFFF.
  - forced_cnt (16-bit): counts starvation-forced dbg grants; wraps at 0xFFFF.
  - Both are cleared by rst_n.
- Without it: no extra ports and no counter logic.

Decomposition:
- Package dmem_arb_pkg holds:
  - enum arb_state_e {IDLE, DBG_LOCKED};
  - enum owner_e {NONE, CORE, DBG};
  - struct mem_req_t {we, addr, wdata}, parameterised by the package constants ADDR_W/DATA_W.
- Natural sub-module: dmem_arb_starve_ctr (saturating counter with clear), instantiated once.

Test Plan:
- Core-only read:
  - Stimulus: core_req=1, we=0, addr=0x10 with RAM[0x10]=0xA5.
  - Required: core_gnt=1 the same cycle; core_rvalid=1 and rdata=0xA5 the next cycle.
- Conflict with starvation, STARVE_LIMIT=4:
  - Stimulus: core_req and dbg_req held high.
  - Required: core granted on cycles 0–3, dbg granted on cycle 4, starve_cnt back to 0; the pattern repeats every 5 cycles.
- Debug locked burst:
  - Stimulus: dbg_lock=1 with dbg writes 0x01..0x04 to 0x20..0x23 while core_req=1.
  - Required: core_gnt=0 throughout; RAM holds the values afterwards; core granted the cycle after dbg_lock drops.
- Alternating reads:
  - Stimulus: core read 0x00, then dbg read 0x01 in consecutive cycles.
  - Required: core_rvalid in cycle 1, dbg_rvalid in cycle 2, each with the correct data and no cross-delivery.
- Async reset mid-read:
  - Stimulus: rst_n low between a read grant and its return.
  - Required: no rvalid; all outputs 0 immediately; state IDLE.
- DMEM_ARB_STATS_EN:
  - Stimulus: 10 cycles of both requesting, STARVE_LIMIT=4.
  - Required: conflict_cnt=10, forced_cnt=2.
